// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forwarding select encodings, Tuse/Tnew constants and the pipe entry layout.
package hazard_ctrl_pkg;

  // Width of the Tnew field stored in each in-flight entry.
  localparam int ENTRY_TNEW_W = 3;

  // Forwarding source selects, shared by D- and E-stage operands.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwdSelT;

  // Tuse value meaning "operand not read".
  localparam logic [ENTRY_TNEW_W-1:0] TUSE_NONE = 3'd3;

  // Cycles after entering E until the result can be forwarded.
  localparam logic [ENTRY_TNEW_W-1:0] TNEW_CALC = 3'd1;
  localparam logic [ENTRY_TNEW_W-1:0] TNEW_LOAD = 3'd2;
  localparam logic [ENTRY_TNEW_W-1:0] TNEW_LINK = 3'd0;

  // One in-flight instruction as tracked through E, M and W.
  typedef struct packed {
    logic [4:0]              waddr;
    logic [ENTRY_TNEW_W-1:0] tnew;
    logic [4:0]              rs;
    logic [4:0]              rt;
    logic                    md;
    logic                    isDiv;
  } pipeEntryT;

  // A bubble writes $0, so it can never match an operand.
  localparam pipeEntryT BUBBLE = '0;

  // True when the entry writes the (non-zero) register idx.
  function automatic logic regMatch(input logic [4:0] idx, input pipeEntryT ent);
    return (idx != 5'd0) && (ent.waddr == idx);
  endfunction

  // True when the entry's result arrives too late for an operand needed at tuse.
  function automatic logic stageStalls(input logic [4:0] idx,
                                       input logic [ENTRY_TNEW_W-1:0] tuse,
                                       input pipeEntryT ent);
    return regMatch(idx, ent) && (ent.tnew > tuse);
  endfunction

  // One stage older: Tnew counts down and holds at zero.
  function automatic pipeEntryT ageEntry(input pipeEntryT ent);
    pipeEntryT r;
    r = ent;
    if (r.tnew != '0) r.tnew = r.tnew - ENTRY_TNEW_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder-side bundle: D-stage instruction attributes and flush in,
// stall / forwarding selects / MDU status out.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int TNEW_W = ENTRY_TNEW_W
);
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic [4:0]        d_waddr;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md;
  logic              d_is_div;
  logic              d_mdu_acc;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_rs_d;
  logic [1:0]        fwd_rt_d;
  logic [1:0]        fwd_rs_e;
  logic [1:0]        fwd_rt_e;
  logic              mdu_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_waddr, d_tnew,
           d_md, d_is_div, d_mdu_acc, flush,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, mdu_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_waddr, d_tnew,
           d_md, d_is_div, d_mdu_acc, flush,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, mdu_busy
  );
endinterface

// File: rtl/hazard_mdu_timer.sv
// Multi-cycle multiply/divide occupancy counter. Loads when an md op sits in E
// at a clock edge (unless flushed), then counts down to zero.
module hazard_mdu_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic eMd,
  input  logic eIsDiv,
  input  logic flush,
  output logic busy
);

  logic [CNT_W-1:0] cntReg;

  // Load on a live md in E; otherwise drain. Flush does not cancel a running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      cntReg <= '0;
    end else if (eMd && !flush) begin
      cntReg <= eIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cntReg != '0) begin
      cntReg <= cntReg - CNT_W'(1);
    end
  end

  // The op in E counts as busy before its counter has loaded.
  assign busy = (cntReg != '0) | eMd;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline. Tracks the destination
// and Tnew of the instructions in E, M and W and derives the D-stage stall and
// the D/E operand forwarding selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TNEW_W      = ENTRY_TNEW_W,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  pipeEntryT eReg;
  pipeEntryT mReg;
  pipeEntryT wReg;
  pipeEntryT dEntry;

  logic                   mduBusy;
  logic                   stallHz;
  logic [1:0]             opHz;
  logic [1:0][4:0]        dIdx;
  logic [1:0][4:0]        eIdx;
  logic [1:0][TNEW_W-1:0] dTuse;
  logic [1:0][1:0]        fwdD;
  logic [1:0][1:0]        fwdE;

  // Only waddr/tnew of M and waddr of W steer decisions; the rest rides along.
  logic unusedBits;
  assign unusedBits = ^{mReg, wReg};

  assign dIdx[0]  = hz.d_rs;
  assign dIdx[1]  = hz.d_rt;
  assign dTuse[0] = hz.d_tuse_rs;
  assign dTuse[1] = hz.d_tuse_rt;
  assign eIdx[0]  = eReg.rs;
  assign eIdx[1]  = eReg.rt;

  // Pack the decoder's view of the D instruction into an entry.
  always_comb begin
    dEntry       = BUBBLE;
    dEntry.waddr = hz.d_waddr;
    dEntry.tnew  = ENTRY_TNEW_W'(hz.d_tnew);
    dEntry.rs    = hz.d_rs;
    dEntry.rt    = hz.d_rt;
    dEntry.md    = hz.d_md;
    dEntry.isDiv = hz.d_md & hz.d_is_div;
  end

  // Per-operand hazard and forwarding; index 0 is rs, index 1 is rt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic [ENTRY_TNEW_W-1:0] tuse;
      assign tuse = ENTRY_TNEW_W'(dTuse[gi]);

      assign opHz[gi] = stageStalls(dIdx[gi], tuse, eReg)
                      | stageStalls(dIdx[gi], tuse, mReg);

      // Nearest ready producer wins; W is always ready.
      assign fwdD[gi] = (regMatch(dIdx[gi], eReg) && eReg.tnew == '0) ? FWD_E :
                        (regMatch(dIdx[gi], mReg) && mReg.tnew == '0) ? FWD_M :
                        regMatch(dIdx[gi], wReg)                      ? FWD_W :
                                                                        FWD_RF;

      assign fwdE[gi] = (regMatch(eIdx[gi], mReg) && mReg.tnew == '0) ? FWD_M :
                        regMatch(eIdx[gi], wReg)                      ? FWD_W :
                                                                        FWD_RF;
    end
  endgenerate

  assign stallHz = (|opHz) | (hz.d_mdu_acc & mduBusy);

  // Advance the in-flight entries; flush kills E and M, and wins over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      eReg <= BUBBLE;
      mReg <= BUBBLE;
      wReg <= BUBBLE;
    end else begin
      wReg <= mReg;
      mReg <= hz.flush ? BUBBLE : ageEntry(eReg);
      eReg <= (hz.flush || stallHz) ? BUBBLE : dEntry;
    end
  end

  hazard_mdu_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .eMd    (eReg.md),
    .eIsDiv (eReg.isDiv),
    .flush  (hz.flush),
    .busy   (mduBusy)
  );

  assign hz.stall    = stallHz;
  assign hz.fwd_rs_d = fwdD[0];
  assign hz.fwd_rt_d = fwdD[1];
  assign hz.fwd_rs_e = fwdE[0];
  assign hz.fwd_rt_e = fwdE[1];
  assign hz.mdu_busy = mduBusy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios followed by random
// instruction streams, all compared every cycle against an age-based model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.TNEW_W(3)) bus ();

  hazard_ctrl #(
    .TNEW_W      (3),
    .MULT_CYCLES (MULT_C),
    .DIV_CYCLES  (DIV_C),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  // Model: slot index is the age since entering E (0 = E, 1 = M, 2 = W).
  typedef struct {
    int waddr;
    int tnew0;
    int rs;
    int rt;
    bit md;
    bit isDiv;
  } entT;

  entT st[3];
  int  mCnt;
  bit  modelValid = 0;
  bit  lastStall = 0;
  int  errors = 0;
  int  checks = 0;

  int dRs, dRt, dTuseRs, dTuseRt, dWaddr, dTnew;
  bit dMd, dIsDiv, dAcc, dFlush;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int remaining(input int age);
    return (st[age].tnew0 > age) ? st[age].tnew0 - age : 0;
  endfunction

  function automatic bit hit(input int idx, input int age);
    return (idx != 0) && (st[age].waddr == idx);
  endfunction

  function automatic bit hazardOf(input int idx, input int tuse);
    for (int a = 0; a < 2; a++)
      if (hit(idx, a) && remaining(a) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fwdDOf(input int idx);
    for (int a = 0; a < 2; a++)
      if (hit(idx, a) && remaining(a) == 0) return a + 1;
    if (hit(idx, 2)) return 3;
    return 0;
  endfunction

  function automatic int fwdEOf(input int idx);
    if (hit(idx, 1) && remaining(1) == 0) return 2;
    if (hit(idx, 2)) return 3;
    return 0;
  endfunction

  function automatic bit modelBusy();
    return (mCnt != 0) || st[0].md;
  endfunction

  task automatic setD(input int rs, input int rt, input int tur, input int tut,
                      input int wa, input int tn, input bit md, input bit isDiv,
                      input bit acc, input bit fl);
    dRs = rs; dRt = rt; dTuseRs = tur; dTuseRt = tut; dWaddr = wa; dTnew = tn;
    dMd = md; dIsDiv = md & isDiv; dAcc = acc; dFlush = fl;
    bus.d_rs      = 5'(rs);
    bus.d_rt      = 5'(rt);
    bus.d_tuse_rs = 3'(tur);
    bus.d_tuse_rt = 3'(tut);
    bus.d_waddr   = 5'(wa);
    bus.d_tnew    = 3'(tn);
    bus.d_md      = md;
    bus.d_is_div  = md & isDiv;
    bus.d_mdu_acc = acc;
    bus.flush     = fl;
  endtask

  task automatic nop(input bit fl);
    setD(0, 0, TUSE_NONE, TUSE_NONE, 0, 0, 0, 0, 0, fl);
  endtask

  // Called at the falling edge: compare, then advance the model across one clock.
  task automatic mstep();
    entT bub, nE, nM, nW;
    bit  stallNow;
    int  nCnt;
    bub = '{default: 0};
    stallNow = hazardOf(dRs, dTuseRs) | hazardOf(dRt, dTuseRt) | (dAcc && modelBusy());
    lastStall = stallNow;
    if (modelValid) begin
      $display("cyc t=%0t rs=%0d rt=%0d wa=%0d fl=%0d stall=%0d fd=%0d/%0d fe=%0d/%0d busy=%0d",
               $time, dRs, dRt, dWaddr, dFlush, bus.stall, bus.fwd_rs_d, bus.fwd_rt_d,
               bus.fwd_rs_e, bus.fwd_rt_e, bus.mdu_busy);
      chk("stall",    8'(bus.stall),    8'(stallNow));
      chk("fwd_rs_d", 8'(bus.fwd_rs_d), 8'(fwdDOf(dRs)));
      chk("fwd_rt_d", 8'(bus.fwd_rt_d), 8'(fwdDOf(dRt)));
      chk("fwd_rs_e", 8'(bus.fwd_rs_e), 8'(fwdEOf(st[0].rs)));
      chk("fwd_rt_e", 8'(bus.fwd_rt_e), 8'(fwdEOf(st[0].rt)));
      chk("mdu_busy", 8'(bus.mdu_busy), 8'(modelBusy()));
    end
    if (reset) begin
      nE = bub; nM = bub; nW = bub; nCnt = 0;
    end else begin
      if (st[0].md && !dFlush) nCnt = st[0].isDiv ? DIV_C : MULT_C;
      else if (mCnt > 0)       nCnt = mCnt - 1;
      else                     nCnt = 0;
      nW = st[1];
      nM = dFlush ? bub : st[0];
      if (dFlush || stallNow) nE = bub;
      else nE = '{waddr: dWaddr, tnew0: dTnew, rs: dRs, rt: dRt, md: dMd, isDiv: dIsDiv};
    end
    @(posedge clk);
    #1;
    st[0] = nE; st[1] = nM; st[2] = nW; mCnt = nCnt;
    if (reset) modelValid = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      nop(0); @(negedge clk); mstep();
    end
  endtask

  initial begin
    nop(0);
    reset = 1'b1;
    @(negedge clk); mstep();
    @(negedge clk); mstep();
    reset = 1'b0;

    // Reset state.
    nop(0); @(negedge clk);
    chk("rst_stall", 8'(bus.stall), 8'd0);
    chk("rst_fwd_rs_d", 8'(bus.fwd_rs_d), 8'd0);
    chk("rst_fwd_rt_d", 8'(bus.fwd_rt_d), 8'd0);
    chk("rst_fwd_rs_e", 8'(bus.fwd_rs_e), 8'd0);
    chk("rst_fwd_rt_e", 8'(bus.fwd_rt_e), 8'd0);
    chk("rst_busy", 8'(bus.mdu_busy), 8'd0);
    mstep();

    // lw $1 ; addu $2,$1,$3 : one stall, then W forward into E.
    setD(0, 0, 1, TUSE_NONE, 1, TNEW_LOAD, 0, 0, 0, 0); @(negedge clk);
    chk("lw_addu_s0", 8'(bus.stall), 8'd0); mstep();
    setD(1, 3, 1, 1, 2, TNEW_CALC, 0, 0, 0, 0); @(negedge clk);
    chk("lw_addu_s1", 8'(bus.stall), 8'd1); mstep();
    setD(1, 3, 1, 1, 2, TNEW_CALC, 0, 0, 0, 0); @(negedge clk);
    chk("lw_addu_s2", 8'(bus.stall), 8'd0); mstep();
    nop(0); @(negedge clk);
    chk("lw_addu_fwdE", 8'(bus.fwd_rs_e), 8'd3); mstep();
    drain();

    // lw $1 ; beq $1,$0 : two stalls, then W forward into D.
    setD(0, 0, 1, TUSE_NONE, 1, TNEW_LOAD, 0, 0, 0, 0); @(negedge clk); mstep();
    for (int i = 0; i < 2; i++) begin
      setD(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
      chk("lw_beq_stall", 8'(bus.stall), 8'd1); mstep();
    end
    setD(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("lw_beq_go", 8'(bus.stall), 8'd0);
    chk("lw_beq_fwd", 8'(bus.fwd_rs_d), 8'd3); mstep();
    drain();

    // addu $1 ; beq $1 : one stall, then M forward.
    setD(2, 3, 1, 1, 1, TNEW_CALC, 0, 0, 0, 0); @(negedge clk); mstep();
    setD(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("calc_beq_stall", 8'(bus.stall), 8'd1); mstep();
    setD(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("calc_beq_go", 8'(bus.stall), 8'd0);
    chk("calc_beq_fwd", 8'(bus.fwd_rs_d), 8'd2); mstep();
    drain();

    // jal ; jr $31 : E forward, no stall.
    setD(0, 0, TUSE_NONE, TUSE_NONE, 31, TNEW_LINK, 0, 0, 0, 0); @(negedge clk); mstep();
    setD(31, 0, 0, TUSE_NONE, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("jal_jr_stall", 8'(bus.stall), 8'd0);
    chk("jal_jr_fwd", 8'(bus.fwd_rs_d), 8'd1); mstep();
    drain();

    // ori $0 ; addu $5,$0,$0 : $0 never stalls or forwards.
    setD(0, 0, 1, TUSE_NONE, 0, TNEW_CALC, 0, 0, 0, 0); @(negedge clk); mstep();
    setD(0, 0, 1, 1, 5, TNEW_CALC, 0, 0, 0, 0); @(negedge clk);
    chk("zero_stall", 8'(bus.stall), 8'd0);
    chk("zero_fwd_rs_d", 8'(bus.fwd_rs_d), 8'd0);
    chk("zero_fwd_rt_d", 8'(bus.fwd_rt_d), 8'd0); mstep();
    nop(0); @(negedge clk);
    chk("zero_fwd_rs_e", 8'(bus.fwd_rs_e), 8'd0);
    chk("zero_fwd_rt_e", 8'(bus.fwd_rt_e), 8'd0); mstep();
    drain();

    // div ; mflo : busy and stall for DIV_CYCLES+1 cycles.
    setD(0, 0, 1, 1, 0, 0, 1, 1, 1, 0); @(negedge clk);
    chk("div_issue", 8'(bus.stall), 8'd0); mstep();
    for (int i = 0; i <= DIV_C; i++) begin
      setD(0, 0, TUSE_NONE, TUSE_NONE, 5, TNEW_CALC, 0, 0, 1, 0); @(negedge clk);
      chk("div_mflo_stall", 8'(bus.stall), 8'd1);
      chk("div_busy", 8'(bus.mdu_busy), 8'd1); mstep();
    end
    setD(0, 0, TUSE_NONE, TUSE_NONE, 5, TNEW_CALC, 0, 0, 1, 0); @(negedge clk);
    chk("div_mflo_go", 8'(bus.stall), 8'd0);
    chk("div_idle", 8'(bus.mdu_busy), 8'd0); mstep();
    drain();

    // mult ; mfhi : MULT_CYCLES+1 stall cycles.
    setD(0, 0, 1, 1, 0, 0, 1, 0, 1, 0); @(negedge clk); mstep();
    for (int i = 0; i <= MULT_C; i++) begin
      setD(0, 0, TUSE_NONE, TUSE_NONE, 6, TNEW_CALC, 0, 0, 1, 0); @(negedge clk);
      chk("mult_mfhi_stall", 8'(bus.stall), 8'd1); mstep();
    end
    setD(0, 0, TUSE_NONE, TUSE_NONE, 6, TNEW_CALC, 0, 0, 1, 0); @(negedge clk);
    chk("mult_mfhi_go", 8'(bus.stall), 8'd0); mstep();
    drain();

    // lw $4 in E when flushed; addu $6,$4 in D sees no hazard afterwards.
    setD(0, 0, 1, TUSE_NONE, 4, TNEW_LOAD, 0, 0, 0, 0); @(negedge clk); mstep();
    setD(4, 0, 1, 1, 6, TNEW_CALC, 0, 0, 0, 1); @(negedge clk); mstep();
    setD(4, 0, 1, 1, 6, TNEW_CALC, 0, 0, 0, 0); @(negedge clk);
    chk("flush_nostall", 8'(bus.stall), 8'd0);
    chk("flush_fwd", 8'(bus.fwd_rs_d), 8'd0); mstep();
    drain();

    // div killed by flush while in E: counter never loads.
    setD(0, 0, 1, 1, 0, 0, 1, 1, 1, 0); @(negedge clk); mstep();
    nop(1); @(negedge clk);
    chk("mdflush_busyE", 8'(bus.mdu_busy), 8'd1); mstep();
    nop(0); @(negedge clk);
    chk("mdflush_idle", 8'(bus.mdu_busy), 8'd0); mstep();
    drain();

    // Reset in the middle of a divide.
    setD(0, 0, 1, 1, 0, 0, 1, 1, 1, 0); @(negedge clk); mstep();
    nop(0); @(negedge clk); mstep();
    nop(0); @(negedge clk);
    chk("middiv_busy", 8'(bus.mdu_busy), 8'd1); mstep();
    reset = 1'b1;
    nop(0); @(negedge clk); mstep();
    reset = 1'b0;
    setD(0, 0, TUSE_NONE, TUSE_NONE, 5, TNEW_CALC, 0, 0, 1, 0); @(negedge clk);
    chk("middiv_rst_busy", 8'(bus.mdu_busy), 8'd0);
    chk("middiv_rst_stall", 8'(bus.stall), 8'd0); mstep();
    drain();

    // Random instruction stream; a stalled D instruction is held.
    for (int n = 0; n < 400; n++) begin
      bit fl;
      fl = ($urandom_range(0, 15) == 0);
      if (lastStall && !dFlush) begin
        setD(dRs, dRt, dTuseRs, dTuseRt, dWaddr, dTnew, dMd, dIsDiv, dAcc, fl);
      end else begin
        int kind;
        kind = $urandom_range(0, 11);
        if (kind == 0)
          setD($urandom_range(0, 3), $urandom_range(0, 3), 1, 1, 0, 0, 1,
               1'($urandom_range(0, 1)), 1, fl);
        else if (kind == 1)
          setD(0, 0, TUSE_NONE, TUSE_NONE, $urandom_range(0, 3), TNEW_CALC, 0, 0, 1, fl);
        else
          setD($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
               0, 0, 0, fl);
      end
      @(negedge clk); mstep();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised stall/forward controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Sits beside the decoder and takes its per-instruction Tuse/Tnew, destination and MDU class from D.
- Tracks in-flight destinations and their Tnew countdown through E/M/W, plus a multi-cycle MDU busy counter.
- Produces the D-stage stall and the forwarding selects for D and E operands.

Parameters:
- TNEW_W, 3, width of the Tuse/Tnew fields.
- MULT_CYCLES, 5, E-stage busy cycles for mult/multu (range 1..15).
- DIV_CYCLES, 10, E-stage busy cycles for div/divu (range 1..15).
- CNT_W, 4, width of the MDU busy counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- d_rs  in  5  D-stage rs index
- d_rt  in  5  D-stage rt index
- d_tuse_rs  in  TNEW_W  Tuse of rs (3 = unused)
- d_tuse_rt  in  TNEW_W  Tuse of rt (3 = unused)
- d_waddr  in  5  D-stage destination (0 = none)
- d_tnew  in  TNEW_W  cycles after entering E until result ready (calc/mf 1, load 2, jal 0)
- d_md  in  1  D instr is mult/multu/div/divu
- d_is_div  in  1  qualifies d_md: 1 = div/divu
- d_mdu_acc  in  1  D instr is md, mf or mt
- flush  in  1  exception/eret: kill D, E and M
- stall  out  1  freeze F/D, bubble into E
- fwd_rs_d  out  2  D rs source: 0 RF, 1 E, 2 M, 3 W
- fwd_rt_d  out  2  same for rt
- fwd_rs_e  out  2  E rs source: 0 pipe reg, 2 M, 3 W
- fwd_rt_e  out  2  same for rt
- mdu_busy  out  1  MDU occupied

Behaviour:
- Pipe entries E, M and W each hold {waddr, tnew, rs, rt, md, is_div}. Reset clears them all to the bubble value (waddr 0, tnew 0, md 0). All outputs are 0 on the cycle after reset.
- Advance each clock:
  - W ← M.
  - M ← E with tnew saturating-decremented at 0.
  - E ← D fields (tnew unchanged) if !stall && !flush; otherwise E ← bubble.
- flush:
  - E and M become bubbles next cycle; W still takes the old M.
  - The MDU counter is not cleared, so an op already counting completes.
  - An md in E when flush is asserted is killed before its counter loads.
- MDU counter:
  - When entry E holds md=1 on a clock edge (and no flush), cnt ← is_div ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise, if cnt != 0, cnt decrements.
  - mdu_busy = (cnt != 0) | E.md.
- Stall is combinational. stall = rs_hz | rt_hz | mdu_hz.
  - rs_hz: d_rs != 0 and there is a stage s in {E, M} with s.waddr == d_rs and s.tnew > d_tuse_rs. rt_hz is the same check with d_rt.
  - mdu_hz: d_mdu_acc & mdu_busy.
- Forward D (combinational), on index match, index != 0 and matched tnew == 0. Priority E > M > W, so the nearest stage wins; no match gives 0.
- Forward E (combinational), for E.rs/E.rt, using M (tnew 0) then W; otherwise 0. A bubble never matches because waddr is 0.
- Stall and flush asserted together: flush wins and E gets a bubble.
- Write to $0 never forwards and never stalls.

Decomposition:
- Shared package/header holds:
  - FWD_RF/FWD_E/FWD_M/FWD_W encodings
  - TUSE_NONE = 3
  - Tnew constants (TNEW_CALC 1, TNEW_LOAD 2, TNEW_LINK 0)
  - the bubble entry value
- One sub-module is natural: hazard_mdu_timer (counter, load and busy).

Test Plan:
- lw $1 then addu $2,$1,$3 (tuse 1): stall high exactly 1 cycle; next cycle fwd_rs_e=3 (W).
- lw $1 then beq $1,$0 (tuse 0): stall 2 cycles, then fwd_rs_d=3 (W); beq stall 1 cycle after calc then fwd_rs_d=2.
- jal (waddr 31, tnew 0) then jr $31 next cycle: no stall, fwd_rs_d=1 (E).
- ori $0 then addu $5,$0,$0: no stall, all fwd selects 0.
- div then mflo: mdu_busy high for DIV_CYCLES+1 cycles, stall on mflo for that span, releases when cnt reaches 0. With MULT_CYCLES=5, mult then mfhi stalls 6 cycles.
- lw $4 in E with flush asserted, addu $6,$4 in D: next cycle E/M are bubbles, no stall. Reset mid-div: cnt=0, mdu_busy=0 the next cycle.
